// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the fetch stage. It holds the fetch PC and
// advances it by STEP on every non-stalled cycle. It also handles:
//   - stall (PC hold),
//   - branch/jump redirect,
//   - a one-deep pending-redirect buffer, so a redirect raised while the
//     pipe is stalled is applied on the first non-stalled edge,
//   - misaligned-target detection (one-cycle pulse when such a target is
//     loaded),
//   - a registered PC+STEP for link/branch-base use.
//
// Parameters
//   WIDTH        PC width in bits
//   STEP         increment added per advancing cycle
//   RESET_VECTOR PC value loaded on reset
//   ALIGN_BITS   low PC bits forced to zero on redirect; 0 disables the check
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   stall            in   hold the PC this cycle
//   redirect_valid   in   branch/jump taken this cycle
//   redirect_target  in   new PC when redirect_valid=1
//   pc_out           out  current fetch PC (registered)
//   pc_plus_step     out  pc_out+STEP (registered alongside pc_out)
//   fetch_valid      out  pc_out is a valid fetch address this cycle
//   redirect_pending out  a redirect is buffered awaiting stall release
//   misalign_err     out  one-cycle pulse: loaded target had nonzero low bits
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       STEP         = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned       ALIGN_BITS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             fetch_valid,
    output logic             redirect_pending,
    output logic             misalign_err
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_plus;
    logic             r_fetch_valid;
    logic             r_misalign;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_tgt;
    logic             r_pend_mis;

    // Alignment mask: bit is 1 where the target bit survives alignment.
    // With ALIGN_BITS=0 every bit survives and no target is ever misaligned.
    logic [WIDTH-1:0] w_keep_mask;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_keep_mask
        assign w_keep_mask[gi] = (gi >= int'(ALIGN_BITS));
    end

    logic [WIDTH-1:0] w_tgt_aligned;
    logic             w_tgt_mis;

    assign w_tgt_aligned = redirect_target & w_keep_mask;
    assign w_tgt_mis     = |(redirect_target & ~w_keep_mask);

    // Next-PC selection and pending-buffer update.
    // Priority: stalled capture > live redirect > buffered redirect > advance.
    logic [WIDTH-1:0] w_next_pc;
    logic             w_next_mis;
    logic             w_next_pend_valid;
    logic [WIDTH-1:0] w_next_pend_tgt;
    logic             w_next_pend_mis;

    always_comb begin
        w_next_pc         = r_pc;
        w_next_mis        = 1'b0;
        w_next_pend_valid = r_pend_valid;
        w_next_pend_tgt   = r_pend_tgt;
        w_next_pend_mis   = r_pend_mis;

        // During BOOT the PC is held and redirects are ignored.
        if (r_state != ST_BOOT) begin
            if (stall) begin
                if (redirect_valid) begin
                    // Last redirect wins. Alignment is checked now, the
                    // error pulse is raised when the entry is loaded.
                    w_next_pend_valid = 1'b1;
                    w_next_pend_tgt   = w_tgt_aligned;
                    w_next_pend_mis   = w_tgt_mis;
                end
            end else if (redirect_valid) begin
                // Live redirect supersedes anything buffered.
                w_next_pc         = w_tgt_aligned;
                w_next_mis        = w_tgt_mis;
                w_next_pend_valid = 1'b0;
                w_next_pend_tgt   = '0;
                w_next_pend_mis   = 1'b0;
            end else if (r_pend_valid) begin
                w_next_pc         = r_pend_tgt;
                w_next_mis        = r_pend_mis;
                w_next_pend_valid = 1'b0;
                w_next_pend_tgt   = '0;
                w_next_pend_mis   = 1'b0;
            end else begin
                w_next_pc = r_pc + STEP_W;
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pc_plus     <= RESET_VECTOR + STEP_W;
            r_fetch_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_tgt    <= '0;
            r_pend_mis    <= 1'b0;
        end else begin
            r_pc         <= w_next_pc;
            // Derived from the same next value so the pair never disagrees.
            r_pc_plus    <= w_next_pc + STEP_W;
            r_misalign   <= w_next_mis;
            r_pend_valid <= w_next_pend_valid;
            r_pend_tgt   <= w_next_pend_tgt;
            r_pend_mis   <= w_next_pend_mis;

            case (r_state)
                ST_BOOT: begin
                    // Single boot cycle, leaves unconditionally.
                    r_state       <= ST_RUN;
                    r_fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (stall) begin
                        r_state       <= ST_HOLD;
                        r_fetch_valid <= 1'b0;
                    end else begin
                        r_fetch_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end else begin
                        r_fetch_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out           = r_pc;
    assign pc_plus_step     = r_pc_plus;
    assign fetch_valid      = r_fetch_valid;
    assign redirect_pending = r_pend_valid;
    assign misalign_err     = r_misalign;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the fetch stage, the successor to the fixed registered PC+4 adder. It holds the PC register and advances it by a configurable step each cycle. It supports stall (hold), branch/jump redirect, and a one-deep pending-redirect buffer so redirects raised during a stall are not lost. It also flags misaligned redirect targets and outputs a registered PC+STEP for link/branch-base use.

Parameters:
WIDTH, 32, PC width in bits
STEP, 4, increment added per advancing cycle
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
ALIGN_BITS, 2, low PC bits that must be zero; 0 disables alignment checking

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC (hazard unit / IF-ID stall)
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  WIDTH  new PC when redirect_valid=1
pc_out  output  WIDTH  current fetch PC (registered)
pc_plus_step  output  WIDTH  pc_out+STEP (registered, always consistent with pc_out)
fetch_valid  output  1  pc_out is a valid fetch address this cycle
redirect_pending  output  1  a redirect is buffered awaiting stall release
misalign_err  output  1  one-cycle pulse: accepted redirect target had nonzero low ALIGN_BITS

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; all state is cleared on the falling edge of rst_n, independent of clk.
- Reset values: pc_out=RESET_VECTOR, pc_plus_step=RESET_VECTOR+STEP, fetch_valid=0, redirect_pending=0, misalign_err=0, pending target=0, state=BOOT.
- States:
  - BOOT: entered on reset; lasts exactly one clock after rst_n rises; PC held. Goes to RUN unconditionally on the first rising edge; fetch_valid becomes 1 on that edge.
  - RUN: normal operation. Goes to HOLD when stall=1 at the edge.
  - HOLD: PC frozen, fetch_valid=0. Goes to RUN on the first edge with stall=0.
- Next-PC priority, evaluated at each rising edge in RUN/HOLD:
  1. stall=1 and redirect_valid=1: PC held. Target captured into the pending buffer, redirect_pending<=1. A newer redirect overwrites an older pending one (last wins).
  2. stall=1, no redirect: PC held; pending buffer unchanged.
  3. stall=0 and redirect_valid=1: PC<=aligned(redirect_target). Any pending entry is discarded; the live redirect wins over the buffered one.
  4. stall=0, redirect_pending=1: PC<=pending target; redirect_pending<=0.
  5. Otherwise: PC<=PC+STEP.
- redirect_valid during BOOT is ignored.
- aligned(x): x with low ALIGN_BITS forced to 0. misalign_err=1 for exactly the cycle after a target with nonzero low bits is loaded into PC. A pending load counts; the check is made at capture time and the pulse is emitted at load time.
- Arithmetic: all addition is modulo 2^WIDTH. PC wraps from 2^WIDTH-STEP to 0 with no flag.
- pc_plus_step is updated in the same edge as pc_out. It is never combinationally derived from inputs.
- Latency: redirect presented at edge N (no stall) gives pc_out=target after edge N. A stall-buffered redirect is applied at the first non-stall edge.
- Reset asserted mid-stall or with a pending redirect: the pending entry is dropped and the block returns to BOOT.

Test Plan:
1. Reset with RESET_VECTOR=0x0000_0000, release, run 4 edges with no stall -> fetch_valid 0 for the BOOT cycle, then pc_out 0x0, 0x4, 0x8, 0xC; pc_plus_step is always pc_out+4.
2. At pc_out=0x10, stall=1 for 3 cycles -> pc_out holds 0x10 and fetch_valid=0 for those 3 cycles; on release pc_out=0x14.
3. At pc_out=0x20, redirect_valid=1 with target 0x100 while stall=1, then a second redirect to 0x200 while still stalled, then release stall -> redirect_pending=1 during the stall, then pc_out=0x200 and redirect_pending=0.
4. Pending target 0x300 held, release stall in the same cycle as a live redirect to 0x400 -> pc_out=0x400 and the pending entry is cleared.
5. Redirect to 0x103 with ALIGN_BITS=2 -> pc_out=0x100 and misalign_err pulses for exactly 1 cycle.
6. WIDTH=8, STEP=4, PC=0xFC, advance -> pc_out=0x00 and pc_plus_step=0x04. Assert rst_n=0 asynchronously mid-cycle during a stall with a pending redirect -> outputs go to reset values immediately, without waiting for a clock edge.
